// File: rtl/npu_axi_mem_pkg.sv
// Shared constants, FSM state types and beat-size helpers for the NPU AXI memory router.
package npu_axi_mem_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned STRB_W = 32;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  function automatic logic [5:0] beat_bytes(input logic [2:0] size);
    return (size >= 3'd5) ? 6'd32 : (6'd1 << size);
  endfunction

  // Byte lanes that carry data for a beat of the given size.
  function automatic logic [STRB_W-1:0] lane_mask(input logic [2:0] size);
    logic [STRB_W-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < STRB_W; k++) begin
      if (k < 32'(beat_bytes(size))) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/npu_byte_mem.sv
// Byte-addressed array with a 32-lane strobed write port and a 32-lane
// combinational read port; lane k maps to base+k, wrapping modulo the depth.
module npu_byte_mem
  import npu_axi_mem_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wbase,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     rbase,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [7:0] arr [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < STRB_W; k++) begin
        if (wstrb[k]) arr[wbase + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < STRB_W; k++) begin
      rdata[8*k +: 8] = arr[rbase + AW'(k)];
    end
  end

endmodule

// File: rtl/npu_axi_mem_router.sv
// AXI4 slave memory model: each burst is routed by its start address to the
// SRAM window or the flat DRAM array; read and write channels run independently.
module npu_axi_mem_router #(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       DATA_W    = 256,
  parameter int unsigned       MEM_AW    = 21,
  parameter logic [ADDR_W-1:0] SRAM_BASE = 64'h0000_0000_8000_0000,
  parameter int unsigned       SRAM_AW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_axi_awvalid,
  output logic                m_axi_awready,
  input  logic [ADDR_W-1:0]   m_axi_awaddr,
  input  logic [7:0]          m_axi_awlen,
  input  logic [2:0]          m_axi_awsize,
  input  logic                m_axi_wvalid,
  output logic                m_axi_wready,
  input  logic [DATA_W-1:0]   m_axi_wdata,
  input  logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_wlast,
  output logic                m_axi_bvalid,
  input  logic                m_axi_bready,
  input  logic                m_axi_arvalid,
  output logic                m_axi_arready,
  input  logic [ADDR_W-1:0]   m_axi_araddr,
  input  logic [7:0]          m_axi_arlen,
  input  logic [2:0]          m_axi_arsize,
  output logic                m_axi_rvalid,
  input  logic                m_axi_rready,
  output logic [DATA_W-1:0]   m_axi_rdata,
  output logic                m_axi_rlast
);
  import npu_axi_mem_pkg::*;

  w_state_e          w_state, w_state_nx;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic              w_sram;

  r_state_e          r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic              r_sram;

  logic              w_fire;
  logic [STRB_W-1:0] w_strb_eff, r_lanes;
  logic [DATA_W-1:0] dram_rd, sram_rd, r_raw;

  function automatic logic in_sram(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - SRAM_BASE;
    return (a >= SRAM_BASE) && ((off >> SRAM_AW) == '0);
  endfunction

  // Write channel
  always_comb begin
    w_state_nx    = w_state;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    if (rst_n) begin
      case (w_state)
        W_IDLE: begin
          m_axi_awready = 1'b1;
          if (m_axi_awvalid) w_state_nx = W_DATA;
        end
        W_DATA: begin
          m_axi_wready = 1'b1;
          if (m_axi_wvalid && (m_axi_wlast || (w_cnt == w_len))) w_state_nx = W_RESP;
        end
        W_RESP: begin
          m_axi_bvalid = 1'b1;
          if (m_axi_bready) w_state_nx = W_IDLE;
        end
        default: w_state_nx = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_sram  <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (m_axi_awvalid && m_axi_awready) begin
        w_addr <= m_axi_awaddr;
        w_len  <= m_axi_awlen;
        w_size <= m_axi_awsize;
        w_sram <= in_sram(m_axi_awaddr);
        w_cnt  <= '0;
      end else if (w_fire) begin
        w_addr <= w_addr + ADDR_W'(beat_bytes(w_size));
        w_cnt  <= w_cnt + 8'd1;
      end
    end
  end

  assign w_fire     = m_axi_wvalid && m_axi_wready;
  assign w_strb_eff = m_axi_wstrb & lane_mask(w_size);

  // Read channel
  assign r_lanes = lane_mask(r_size);
  assign r_raw   = r_sram ? sram_rd : dram_rd;

  always_comb begin
    r_state_nx    = r_state;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    if (rst_n) begin
      case (r_state)
        R_IDLE: begin
          m_axi_arready = 1'b1;
          if (m_axi_arvalid) r_state_nx = R_DATA;
        end
        R_DATA: begin
          m_axi_rvalid = 1'b1;
          m_axi_rlast  = (r_cnt == r_len);
          for (int unsigned k = 0; k < STRB_W; k++) begin
            m_axi_rdata[8*k +: 8] = r_lanes[k] ? r_raw[8*k +: 8] : 8'h00;
          end
          if (m_axi_rready && (r_cnt == r_len)) r_state_nx = R_IDLE;
        end
        default: r_state_nx = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_sram  <= 1'b0;
    end else begin
      r_state <= r_state_nx;
      if (m_axi_arvalid && m_axi_arready) begin
        r_addr <= m_axi_araddr;
        r_len  <= m_axi_arlen;
        r_size <= m_axi_arsize;
        r_sram <= in_sram(m_axi_araddr);
        r_cnt  <= '0;
      end else if (m_axi_rvalid && m_axi_rready) begin
        r_addr <= r_addr + ADDR_W'(beat_bytes(r_size));
        r_cnt  <= r_cnt + 8'd1;
      end
    end
  end

  // Both arrays see every beat; the latched target gates which one is written.
  npu_byte_mem #(.AW(MEM_AW)) mem (
    .clk   (clk),
    .we    (w_fire && !w_sram),
    .wbase (w_addr[MEM_AW-1:0]),
    .wdata (m_axi_wdata),
    .wstrb (w_strb_eff),
    .rbase (r_addr[MEM_AW-1:0]),
    .rdata (dram_rd)
  );

  npu_byte_mem #(.AW(SRAM_AW)) sram (
    .clk   (clk),
    .we    (w_fire && w_sram),
    .wbase (SRAM_AW'(w_addr - SRAM_BASE)),
    .wdata (m_axi_wdata),
    .wstrb (w_strb_eff),
    .rbase (SRAM_AW'(r_addr - SRAM_BASE)),
    .rdata (sram_rd)
  );

endmodule

// File: tb/tb_npu_axi_mem_router.sv
// Bench for npu_axi_mem_router: constant read vectors, directed multi-cycle
// sequences and random bursts checked against a byte-level memory model.
module tb_npu_axi_mem_router;

  localparam logic [63:0] SRAM_BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned DRAM_SZ   = 1 << 21;
  localparam int unsigned SRAM_SZ   = 1 << 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [255:0] wdata, rdata;
  logic [31:0]  wstrb;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]   mdram [int unsigned];
  logic [7:0]   msram [int unsigned];
  logic [255:0] wbuf [64];
  logic [31:0]  sbuf [64];
  logic [255:0] rbuf [64];
  logic [255:0] src  [8];

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] exp_lo;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  npu_axi_mem_router #(
    .ADDR_W(64), .DATA_W(256), .MEM_AW(21), .SRAM_BASE(SRAM_BASE), .SRAM_AW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rlast(rlast)
  );

  function automatic logic [7:0] init_byte(input int unsigned i);
    logic [31:0] v;
    v = i;
    return v[7:0] ^ v[15:8] ^ {3'b000, v[20:16]};
  endfunction

  function automatic bit is_sram(input logic [63:0] a);
    return (a >= SRAM_BASE) && (a < SRAM_BASE + 64'(SRAM_SZ));
  endfunction

  function automatic int unsigned tgt_idx(input bit s, input logic [63:0] a);
    logic [63:0] off;
    off = s ? (a - SRAM_BASE) % 64'(SRAM_SZ) : a % 64'(DRAM_SZ);
    return off[31:0];
  endfunction

  function automatic int unsigned nbytes(input logic [2:0] size);
    return (size >= 3'd5) ? 32 : (1 << size);
  endfunction

  function automatic logic [7:0] model_rd(input bit s, input int unsigned i);
    if (s) return msram.exists(i) ? msram[i] : 8'h00;
    return mdram.exists(i) ? mdram[i] : init_byte(i);
  endfunction

  function automatic logic [7:0] dut_byte(input bit s, input int unsigned i);
    return s ? dut.sram.arr[i[15:0]] : dut.mem.arr[i[20:0]];
  endfunction

  function automatic logic [255:0] model_beat(input logic [63:0] a, input logic [2:0] size, input int b);
    logic [255:0] v;
    bit s;
    int nb;
    v = '0;
    s = is_sram(a);
    nb = nbytes(size);
    for (int k = 0; k < nb; k++) v[8*k +: 8] = model_rd(s, tgt_idx(s, a + 64'(b*nb + k)));
    return v;
  endfunction

  task automatic model_wr(input logic [63:0] a, input logic [2:0] size, input int b,
                          input logic [255:0] d, input logic [31:0] st);
    bit s;
    int nb;
    int unsigned idx;
    s = is_sram(a);
    nb = nbytes(size);
    for (int k = 0; k < nb; k++) begin
      if (st[k]) begin
        idx = tgt_idx(s, a + 64'(b*nb + k));
        if (s) msram[idx] = d[8*k +: 8];
        else   mdram[idx] = d[8*k +: 8];
      end
    end
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_region(input string name, input logic [63:0] a, input logic [2:0] size, input int nbeats);
    bit s;
    int nb, bad;
    int unsigned idx;
    s = is_sram(a);
    nb = nbytes(size);
    bad = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < nb; k++) begin
        idx = tgt_idx(s, a + 64'(b*nb + k));
        if (dut_byte(s, idx) !== model_rd(s, idx)) bad++;
      end
    end
    check(name, 256'(bad), 256'(0));
  endtask

  task automatic axi_write(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size,
                           input int nbeats, input int wdelay, input int bdelay, input bit abort);
    int t;
    awaddr = a; awlen = len; awsize = size; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    check("aw_accept", 256'(awready), 256'(1));
    @(negedge clk);
    awvalid = 1'b0;
    repeat (wdelay) @(negedge clk);
    for (int b = 0; b < nbeats; b++) begin
      wdata = wbuf[b]; wstrb = sbuf[b]; wvalid = 1'b1;
      wlast = (b == nbeats - 1) && !abort;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      check("wready", 256'(wready), 256'(1));
      model_wr(a, size, b, wbuf[b], sbuf[b]);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!abort) begin
      check("bvalid_latency", 256'(bvalid), 256'(1));
      repeat (bdelay) begin
        @(negedge clk);
        check("bvalid_hold", 256'(bvalid), 256'(1));
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("bvalid_clear", 256'(bvalid), 256'(0));
    end
  endtask

  task automatic axi_read(input logic [63:0] a, input logic [7:0] len, input logic [2:0] size, input bit toggle);
    int t, beat, cyc;
    araddr = a; arlen = len; arsize = size; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check("ar_accept", 256'(arready), 256'(1));
    @(negedge clk);
    arvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      rready = toggle ? (cyc % 2 == 1) : 1'b1;
      check("rvalid", 256'(rvalid), 256'(1));
      check("rdata", rdata, model_beat(a, size, beat));
      check("rlast", 256'(rlast), 256'(beat == int'(len)));
      rbuf[beat] = rdata;
      if (rvalid && rready) beat++;
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check("read_done", 256'(beat), 256'(int'(len) + 1));
    check("rvalid_clear", 256'(rvalid), 256'(0));
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int bad;

    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; awlen = 0; awsize = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; arsize = 0; rready = 0;
    for (int unsigned i = 0; i < DRAM_SZ; i++) dut.mem.arr[i[20:0]] = init_byte(i);
    for (int unsigned i = 0; i < SRAM_SZ; i++) dut.sram.arr[i[15:0]] = 8'h00;

    tv[0] = '{64'h0000_0000_0000_0123, 3'd2, 64'h0000_0000_2724_2522};
    tv[1] = '{64'h0000_0000_0001_0000, 3'd0, 64'h0000_0000_0000_0001};
    tv[2] = '{64'h0000_0000_8000_0000, 3'd3, 64'h0000_0000_0000_0000};
    tv[3] = '{64'h0000_0000_7FFF_FFF8, 3'd3, 64'h1F1E_1D1C_1B1A_1918};
    tv[4] = '{64'h0000_0000_8001_0000, 3'd1, 64'h0000_0000_0000_0001};
    tv[5] = '{64'h0000_0000_0000_0200, 3'd7, 64'h0504_0706_0100_0302};
    tv[6] = '{64'h0000_0000_001F_FFFE, 3'd2, 64'h0000_0000_0100_1F1E};
    tv[7] = '{64'h0000_0001_0000_0123, 3'd2, 64'h0000_0000_2724_2522};

    // Reset: every handshake output low while rst_n is held
    repeat (4) begin
      @(negedge clk);
      check("rst_ready_valid", 256'({awready, arready, bvalid, rvalid}), 256'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 256'(awready), 256'(1));
    check("post_rst_arready", 256'(arready), 256'(1));
    check("post_rst_rdata", rdata, 256'(0));

    // Constant single-beat read vectors
    for (int i = 0; i < 8; i++) begin
      axi_read(tv[i].addr, 8'd0, tv[i].size, 1'b0);
      check($sformatf("vec%0d_lo", i), 256'(rbuf[0][63:0]), 256'(tv[i].exp_lo));
    end

    // DRAM copy 0x0 -> 0x100000
    axi_read(64'h0, 8'd7, 3'd5, 1'b0);
    for (int b = 0; b < 8; b++) begin wbuf[b] = rbuf[b]; sbuf[b] = '1; end
    axi_write(64'h10_0000, 8'd7, 3'd5, 8, 0, 0, 1'b0);
    bad = 0;
    for (int unsigned j = 0; j < 256; j++)
      if (dut.mem.arr[21'h10_0000 + j[20:0]] !== init_byte(j)) bad++;
    check("dram_copy", 256'(bad), 256'(0));

    // Partial strobe, late wvalid, stalled bready
    wbuf[0] = rand256(); sbuf[0] = 32'h0000_000F;
    axi_write(64'h2000, 8'd0, 3'd5, 1, 3, 5, 1'b0);
    check_region("strobe_region", 64'h2000, 3'd5, 1);

    // SRAM round trip into DRAM 0x10000
    for (int b = 0; b < 8; b++) begin src[b] = rand256(); wbuf[b] = src[b]; sbuf[b] = '1; end
    axi_write(SRAM_BASE, 8'd7, 3'd5, 8, 0, 1, 1'b0);
    axi_read(SRAM_BASE, 8'd7, 3'd5, 1'b0);
    for (int b = 0; b < 8; b++) wbuf[b] = rbuf[b];
    axi_write(64'h1_0000, 8'd7, 3'd5, 8, 0, 0, 1'b0);
    bad = 0;
    for (int unsigned j = 0; j < 256; j++)
      if (dut.mem.arr[21'h1_0000 + j[20:0]] !== src[j / 32][8*(j % 32) +: 8]) bad++;
    check("sram_round_trip", 256'(bad), 256'(0));
    bad = 0;
    for (int unsigned j = 0; j < 256; j++)
      if (dut.mem.arr[j[20:0]] !== init_byte(j)) bad++;
    check("dram_alias_untouched", 256'(bad), 256'(0));

    // Concurrent read (stalling) and write
    for (int b = 0; b < 4; b++) begin wbuf[b] = rand256(); sbuf[b] = '1; end
    fork
      axi_read(64'h1000, 8'd3, 3'd5, 1'b1);
      axi_write(64'h3000, 8'd3, 3'd5, 4, 0, 0, 1'b0);
    join
    check_region("concurrent_write", 64'h3000, 3'd5, 4);

    // Early wlast on a longer burst
    for (int b = 0; b < 2; b++) begin wbuf[b] = rand256(); sbuf[b] = '1; end
    axi_write(64'h4000, 8'd3, 3'd5, 2, 0, 0, 1'b0);
    check_region("early_wlast", 64'h4000, 3'd5, 4);

    // Reset after two of four beats
    for (int b = 0; b < 2; b++) begin wbuf[b] = rand256(); sbuf[b] = '1; end
    axi_write(64'h5000, 8'd3, 3'd5, 2, 0, 0, 1'b1);
    check("midrst_no_bvalid", 256'(bvalid), 256'(0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 256'({awready, wready, bvalid, arready, rvalid}), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", 256'({awready, wready, bvalid}), 256'(3'b100));
    check_region("midrst_persist", 64'h5000, 3'd5, 4);

    // Random bursts against the model
    for (int n = 0; n < 40; n++) begin
      int r, len, size;
      r = $urandom_range(0, 4);
      case (r)
        0: a = 64'($urandom_range(32'h2_0000, DRAM_SZ - 1));
        1: a = {32'h0000_1234, 11'h0, 21'($urandom)};
        2: a = SRAM_BASE + 64'($urandom_range(0, SRAM_SZ - 1));
        3: a = SRAM_BASE + 64'($urandom_range(32'hFF00, 32'hFFFF));
        default: a = SRAM_BASE + 64'(SRAM_SZ) + 64'($urandom_range(0, 4095));
      endcase
      len  = $urandom_range(0, 7);
      size = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin wbuf[b] = rand256(); sbuf[b] = $urandom; end
        axi_write(a, 8'(len), 3'(size), len + 1, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        check_region("rand_write", a, 3'(size), len + 1);
      end else begin
        axi_read(a, 8'(len), 3'(size), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
